rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8_pkg.sv | 21 ++
 rtl/rr_arbiter8_log2.sv | 28 ++
 rtl/rr_arbiter8.sv | 114 +++++++++++
 tb/tb_rr_arbiter8.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ   : number of requesters sharing the resource
//   IDX_W   : width of a requester index
//   state_e : arbiter state (idle / grant held)
//   idx_inc : next index with wrap from N_REQ-1 back to 0
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // N_REQ is a power of two, so natural overflow of the index gives the wrap.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return i + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter8_log2.sv
// One-hot to binary index encoder (log2 of a one-hot vector).
// Ports:
//   onehot : one-hot (or all-zero) input vector
//   idx    : index of the set bit, 0 when the input is all zero
module rr_arbiter8_log2
    import rr_arbiter8_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = IDX_W
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    // Output bit gi is the OR of every input position whose index has bit gi set.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic [N-1:0] sel;
        for (genvar gj = 0; gj < N; gj++) begin : g_sel
            if (((gj >> gi) % 2) == 1) begin : g_on
                assign sel[gj] = onehot[gj];
            end else begin : g_off
                assign sel[gj] = 1'b0;
            end
        end
        assign idx[gi] = |sel;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with a bounded hold time.
// A holder keeps the grant while it keeps its request high, up to MAX_HOLD
// cycles; then the grant is withdrawn (expired pulse). Every grant is followed
// by at least one idle cycle, and the search pointer moves past the last holder.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request vector, bit i from requester i
//   grant     : registered one-hot grant, zero when idle
//   grant_idx : binary index of the granted requester, 0 when idle
//   busy      : high while any grant bit is set
//   expired   : one-cycle pulse on the first idle cycle after a timeout
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             expired
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q,   state_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             expired_q, expired_d;
    logic             holding;

    // Rotate so that position ptr becomes bit 0, keep the lowest set bit,
    // then rotate back to the original bit positions.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [N_REQ-1:0] rot;
        logic [N_REQ-1:0] pri;
        rot = (r >> p) | (r << (N_REQ - int'(p)));
        pri = rot & (~rot + N_REQ'(1));
        return (pri << p) | (pri >> (N_REQ - int'(p)));
    endfunction

    rr_arbiter8_log2 #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_log2 (
        .onehot (grant_q),
        .idx    (grant_idx)
    );

    assign holding = |(req & grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = rr_pick(req, ptr_q);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A dropped request wins over a simultaneous timeout.
                if (!holding) begin
                    grant_d = '0;
                    ptr_d   = idx_inc(grant_idx);
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    grant_d   = '0;
                    ptr_d     = idx_inc(grant_idx);
                    expired_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = |grant_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

    localparam int NI = 3;
    localparam int HOLD [NI] = '{4, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant   [NI];
    logic [2:0] gidx    [NI];
    logic       busy    [NI];
    logic       expired [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        rr_arbiter8 #(.MAX_HOLD(HOLD[gi])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req),
            .grant     (grant[gi]),
            .grant_idx (gidx[gi]),
            .busy      (busy[gi]),
            .expired   (expired[gi])
        );
    end

    // Reference model: holder index (-1 when idle), next search start,
    // cycles the current holder has owned the resource, expired pulse.
    int m_g   [NI];
    int m_ptr [NI];
    int m_cnt [NI];
    bit m_exp [NI];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_g[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_exp[k] = 0;
        end
    endtask

    // Drive req for one clock edge, advance the model, sample 1 time unit later.
    task automatic cycle(input logic [7:0] r);
        req = r;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (m_g[k] < 0) begin
                bit found;
                found = 0;
                m_exp[k] = 0;
                for (int j = 0; j < 8; j++) begin
                    int i;
                    i = (m_ptr[k] + j) % 8;
                    if (!found && r[i]) begin
                        found = 1; m_g[k] = i; m_cnt[k] = 1;
                    end
                end
            end else if (!r[m_g[k]]) begin
                m_ptr[k] = (m_g[k] + 1) % 8; m_g[k] = -1; m_exp[k] = 0;
            end else if (m_cnt[k] == HOLD[k]) begin
                m_ptr[k] = (m_g[k] + 1) % 8; m_g[k] = -1; m_exp[k] = 1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1; m_exp[k] = 0;
            end
        end
        #1;
    endtask

    function automatic logic [12:0] exp_vec(input int k);
        logic [7:0] g;
        logic [2:0] ix;
        g  = (m_g[k] < 0) ? 8'h00 : 8'(1 << m_g[k]);
        ix = (m_g[k] < 0) ? 3'd0 : 3'(m_g[k]);
        return {g, ix, m_g[k] >= 0, m_exp[k]};
    endfunction

    function automatic logic [12:0] obs_vec(input int k);
        return {grant[k], gidx[k], busy[k], expired[k]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if ({grant[k], gidx[k], busy[k], expired[k]} !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_state h=%0d: got grant=%h idx=%0d busy=%b expired=%b, want all 0",
                         HOLD[k], grant[k], gidx[k], busy[k], expired[k]);
            end
        end
        rst_n = 1'b1;
        cycle(8'hFF);
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (grant[k] !== 8'h01 || gidx[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL first_grant h=%0d: got grant=%h idx=%0d, want 01 idx 0",
                         HOLD[k], grant[k], gidx[k]);
            end
        end
    endtask

    task automatic test_release_pair();
        logic [7:0] rq [9];
        logic [7:0] eg [9];
        rq = '{8'h24, 8'h24, 8'h24, 8'h20, 8'h24, 8'h24, 8'h24, 8'h04, 8'h24};
        eg = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h20, 8'h20, 8'h20, 8'h00, 8'h04};
        cycle(8'h00);
        cycle(8'h00);
        for (int s = 0; s < 9; s++) begin
            cycle(rq[s]);
            n_tests++;
            if (grant[0] !== eg[s] || expired[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL release_pair step %0d: got grant=%h expired=%b, want grant=%h expired=0",
                         s, grant[0], expired[0], eg[s]);
            end
            for (int k = 0; k < NI; k++) begin
                n_tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL release_pair_model h=%0d step %0d: got {grant,idx,busy,exp}=%h want %h",
                             HOLD[k], s, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_timeout();
        cycle(8'h00);
        cycle(8'h00);
        for (int s = 0; s < 10; s++) begin
            logic [7:0] eg;
            logic       ee;
            cycle(8'h80);
            eg = ((s % 5) == 4) ? 8'h00 : 8'h80;
            ee = ((s % 5) == 4);
            n_tests++;
            if (grant[0] !== eg || expired[0] !== ee) begin
                n_fail++;
                $display("FAIL timeout step %0d: got grant=%h expired=%b, want grant=%h expired=%b",
                         s, grant[0], expired[0], eg, ee);
            end
            for (int k = 0; k < NI; k++) begin
                n_tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL timeout_model h=%0d step %0d: got {grant,idx,busy,exp}=%h want %h",
                             HOLD[k], s, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    // MAX_HOLD=2 instance: order 0..7 then 0, two granted cycles plus one gap.
    task automatic test_all_requesters();
        cycle(8'h00);
        cycle(8'h00);
        for (int s = 0; s < 27; s++) begin
            logic [7:0] eg;
            logic       ee;
            int         ix;
            cycle(8'hFF);
            ix = (s / 3) % 8;
            eg = ((s % 3) == 2) ? 8'h00 : 8'(1 << ix);
            ee = ((s % 3) == 2);
            n_tests++;
            if (grant[1] !== eg || expired[1] !== ee || (eg != 0 && gidx[1] !== 3'(ix))) begin
                n_fail++;
                $display("FAIL all_req step %0d: got grant=%h idx=%0d expired=%b, want grant=%h idx=%0d expired=%b",
                         s, grant[1], gidx[1], expired[1], eg, ix, ee);
            end
            if (s == 0) begin
                n_tests++;
                if (grant[0] !== 8'h01) begin
                    n_fail++;
                    $display("FAIL ptr_wrap: got grant=%h, want 01", grant[0]);
                end
            end
            for (int k = 0; k < NI; k++) begin
                n_tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL all_req_model h=%0d step %0d: got {grant,idx,busy,exp}=%h want %h",
                             HOLD[k], s, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_drop_on_last();
        cycle(8'h00);
        cycle(8'h00);
        for (int s = 0; s < 5; s++) begin
            cycle((s < 4) ? 8'h01 : 8'h00);
            n_tests++;
            if (grant[0] !== ((s < 4) ? 8'h01 : 8'h00) || expired[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_on_last step %0d: got grant=%h expired=%b, want grant=%h expired=0",
                         s, grant[0], expired[0], (s < 4) ? 8'h01 : 8'h00);
            end
            for (int k = 0; k < NI; k++) begin
                n_tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL drop_model h=%0d step %0d: got {grant,idx,busy,exp}=%h want %h",
                             HOLD[k], s, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        r = 8'(($urandom));
        for (int s = 0; s < 400; s++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            cycle(r);
            for (int k = 0; k < NI; k++) begin
                n_tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random h=%0d step %0d req=%h: got {grant,idx,busy,exp}=%h want %h",
                             HOLD[k], s, r, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(8'h00);
        cycle(8'h00);
        cycle(8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (grant[k] !== 8'h00 || busy[k] !== 1'b0 || expired[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset h=%0d: got grant=%h busy=%b expired=%b, want 00/0/0",
                         HOLD[k], grant[k], busy[k], expired[k]);
            end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(8'hFF);
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (obs_vec(k) !== exp_vec(k) || grant[k] !== 8'h01) begin
                n_fail++;
                $display("FAIL async_reset_ptr h=%0d: got {grant,idx,busy,exp}=%h want %h",
                         HOLD[k], obs_vec(k), exp_vec(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_release_pair();
        test_timeout();
        test_all_requesters();
        test_drop_on_last();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
